// File: rtl/mult_acc_pipe.sv
// mult_acc_pipe: 3-stage pipelined multiply-add / accumulate with a sticky overflow flag
module mult_acc_pipe #(
  parameter int A_W    = 16,
  parameter int B_W    = 16,
  parameter int C_W    = 16,
  parameter int P_W    = 48,
  parameter int SIGNED = 0
) (
  input  logic           clk,
  input  logic           SCLR,
  input  logic           CE,
  input  logic           in_valid,
  input  logic [A_W-1:0] A,
  input  logic [B_W-1:0] B,
  input  logic [C_W-1:0] C,
  input  logic           SUBTRACT,
  input  logic           ACC_EN,
  input  logic           ACC_LOAD,
  output logic           out_valid,
  output logic [P_W-1:0] P,
  output logic [P_W-1:0] PCOUT,
  output logic           OVF
);
  localparam int M_W = A_W + B_W;
  localparam logic SX = SIGNED != 0;
  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  logic [C_W-1:0] c1_q, c2_q;
  logic [2:0]     ctl1_q, ctl2_q;
  logic           v1_q, v2_q, vo_q, ovf_q, ovf_d;
  logic [M_W-1:0] m_d, m_q;
  logic [P_W-1:0] p_q;
  logic [P_W:0]   em_d, base_d, res_d;
  // extending both operands to the full product width makes one multiplier serve both modes
  assign m_d    = {{B_W{SX & a_q[A_W-1]}}, a_q} * {{A_W{SX & b_q[B_W-1]}}, b_q};
  assign em_d   = {{(P_W+1-M_W){SX & m_q[M_W-1]}}, m_q};
  assign base_d = (ctl2_q[1] && !ctl2_q[0]) ? {SX & p_q[P_W-1], p_q}
                                            : {{(P_W+1-C_W){SX & c2_q[C_W-1]}}, c2_q};
  assign res_d  = ctl2_q[2] ? base_d - em_d : base_d + em_d;
  assign ovf_d  = SX ? res_d[P_W] ^ res_d[P_W-1] : res_d[P_W];
  always_ff @(posedge clk) begin
    if (SCLR) begin
      a_q    <= '0;
      b_q    <= '0;
      c1_q   <= '0;
      c2_q   <= '0;
      ctl1_q <= '0;
      ctl2_q <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      vo_q   <= 1'b0;
      m_q    <= '0;
      p_q    <= '0;
      ovf_q  <= 1'b0;
    end else if (CE) begin
      a_q    <= A;
      b_q    <= B;
      c1_q   <= C;
      ctl1_q <= {SUBTRACT, ACC_EN, ACC_LOAD};
      v1_q   <= in_valid;
      m_q    <= m_d;
      c2_q   <= c1_q;
      ctl2_q <= ctl1_q;
      v2_q   <= v1_q;
      vo_q   <= v2_q;
      if (v2_q) begin
        p_q   <= res_d[P_W-1:0];
        ovf_q <= ovf_q | ovf_d;
      end
    end
  end
  assign out_valid = vo_q;
  assign P         = p_q;
  assign PCOUT     = p_q;
  assign OVF       = ovf_q;
endmodule
